// File: rtl/sigmoid_arbiter.sv
// Round-robin front end for one shared multi-cycle sigmoid unit: accepts one
// pre-activation, holds the unit's operand for the whole divide, and returns the result or a timeout NaN.
module sigmoid_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst_l,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [2:0]                   round_mode,
  output logic [DATA_W-1:0]            sig_in_x,
  output logic                         sig_in_valid,
  output logic [2:0]                   sig_round_mode,
  input  logic                         sig_out_valid,
  input  logic [DATA_W-1:0]            sig_out_sigmoid,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic                         rsp_err,
  output logic                         busy
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] NAN_W   = DATA_W'(32'h7fc00000);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_RESP} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PTR_W-1:0]  id;
    logic              err;
  } rsp_t;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [2:0]        rm_q, rm_d;
  logic [PTR_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  rsp_t              rsp_q, rsp_d;

  logic [DATA_W-1:0] req_x [NUM_REQ];
  logic              gnt_found;
  logic [PTR_W-1:0]  gnt_idx, cand;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    assign req_x[g] = req_data[g*DATA_W +: DATA_W];
  end

  // Rotating priority: scan upward from the slot after the last winner.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PTR_W'((int'(last_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (gnt_found) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_WAIT;
      S_WAIT: begin
        if (sig_out_valid)         state_d = S_CAPTURE;
        else if (cnt_q == CNT_MAX) state_d = S_RESP;
      end
      S_CAPTURE: state_d = S_RESP;
      S_RESP:    if (rsp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (rst_l && state_q == S_IDLE && gnt_found) req_ready = NUM_REQ'(1) << gnt_idx;
    sig_in_valid = (state_q == S_ISSUE);
    rsp_valid    = (state_q == S_RESP);
    busy         = (state_q != S_IDLE);
  end

  // Datapath next-state; a done pulse on the expiry cycle still takes the capture path.
  always_comb begin
    x_d    = x_q;
    rm_d   = rm_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    rsp_d  = rsp_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          x_d      = req_x[gnt_idx];
          rm_d     = round_mode;
          last_d   = gnt_idx;
          rsp_d.id = gnt_idx;
        end
      end
      S_ISSUE: cnt_d = '0;
      S_WAIT: begin
        if (!sig_out_valid) begin
          if (cnt_q == CNT_MAX) begin
            rsp_d.data = NAN_W;
            rsp_d.err  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      // The unit's result register is valid only one edge after its done pulse.
      S_CAPTURE: begin
        rsp_d.data = sig_out_sigmoid;
        rsp_d.err  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      x_q    <= '0;
      rm_q   <= '0;
      last_q <= PTR_W'(NUM_REQ - 1);
      cnt_q  <= '0;
      rsp_q  <= '0;
    end else begin
      x_q    <= x_d;
      rm_q   <= rm_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
      rsp_q  <= rsp_d;
    end
  end

  assign sig_in_x       = x_q;
  assign sig_round_mode = rm_q;
  assign rsp_data       = rsp_q.data;
  assign rsp_id         = rsp_q.id;
  assign rsp_err        = rsp_q.err;

endmodule
